// File: rtl/des_subkey_sequencer_if.sv
// rtl/des_subkey_sequencer_if.sv - load and round-subkey handshake bundle for the DES subkey sequencer
interface des_subkey_sequencer_if #(
  parameter int KEY_W = 48
);
  // Subkeys from the combinational key schedule; bit KEY_W-1 is DES bit 1.
  logic [KEY_W-1:0] K1,  K2,  K3,  K4;
  logic [KEY_W-1:0] K5,  K6,  K7,  K8;
  logic [KEY_W-1:0] K9,  K10, K11, K12;
  logic [KEY_W-1:0] K13, K14, K15, K16;
  logic             load_valid;
  logic             load_ready;
  logic             decrypt;
  logic             abort;
  logic [KEY_W-1:0] subkey_out;
  logic             subkey_valid;
  logic             subkey_ready;
  logic [3:0]       round_cnt;
  logic [3:0]       key_sel;
  logic             last_round;
  logic             done;

  modport master (
    output K1, K2, K3, K4, K5, K6, K7, K8,
    output K9, K10, K11, K12, K13, K14, K15, K16,
    output load_valid, decrypt, abort, subkey_ready,
    input  load_ready, subkey_out, subkey_valid, round_cnt, key_sel, last_round, done
  );

  modport slave (
    input  K1, K2, K3, K4, K5, K6, K7, K8,
    input  K9, K10, K11, K12, K13, K14, K15, K16,
    input  load_valid, decrypt, abort, subkey_ready,
    output load_ready, subkey_out, subkey_valid, round_cnt, key_sel, last_round, done
  );
endinterface

// File: rtl/des_subkey_sequencer.sv
// rtl/des_subkey_sequencer.sv - captures 16 DES subkeys and streams them forward or reversed, one per round
module des_subkey_sequencer #(
  parameter int KEY_W = 48
) (
  input logic                  clk,
  input logic                  rst_n,
  des_subkey_sequencer_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [KEY_W-1:0] bank [16];
  logic [KEY_W-1:0] load_keys [16];
  logic             mode, mode_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [3:0]       cnt_inc;
  logic [KEY_W-1:0] out_q, out_nxt;
  logic [3:0]       sel_q, sel_nxt;
  logic             last_q, last_nxt;
  logic             done_q, done_nxt;
  logic             load_take;

  // Gather the schedule outputs into an indexable view (index 0 = K1).
  assign load_keys[0]  = bus.K1;
  assign load_keys[1]  = bus.K2;
  assign load_keys[2]  = bus.K3;
  assign load_keys[3]  = bus.K4;
  assign load_keys[4]  = bus.K5;
  assign load_keys[5]  = bus.K6;
  assign load_keys[6]  = bus.K7;
  assign load_keys[7]  = bus.K8;
  assign load_keys[8]  = bus.K9;
  assign load_keys[9]  = bus.K10;
  assign load_keys[10] = bus.K11;
  assign load_keys[11] = bus.K12;
  assign load_keys[12] = bus.K13;
  assign load_keys[13] = bus.K14;
  assign load_keys[14] = bus.K15;
  assign load_keys[15] = bus.K16;

  assign cnt_inc = cnt + 4'd1;

  // Next-state and next-output decode; abort overrides both load and accept.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    sel_nxt   = sel_q;
    last_nxt  = last_q;
    done_nxt  = 1'b0;
    load_take = 1'b0;

    if (bus.abort) begin
      // Drop back to IDLE and hide the bank; the stored keys simply stay put.
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
      out_nxt   = '0;
      sel_nxt   = 4'd0;
      last_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            load_take = 1'b1;
            mode_nxt  = bus.decrypt;
            cnt_nxt   = 4'd0;
            sel_nxt   = bus.decrypt ? 4'd15 : 4'd0;
            out_nxt   = bus.decrypt ? bus.K16 : bus.K1;
            last_nxt  = 1'b0;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (bus.subkey_ready) begin
            if (cnt == 4'd15) begin
              state_nxt = IDLE;
              cnt_nxt   = 4'd0;
              done_nxt  = 1'b1;
              out_nxt   = '0;
              sel_nxt   = 4'd0;
              last_nxt  = 1'b0;
            end else begin
              cnt_nxt  = cnt_inc;
              sel_nxt  = mode ? (4'd15 - cnt_inc) : cnt_inc;
              out_nxt  = bank[sel_nxt];
              last_nxt = (cnt_inc == 4'd15);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequence counter, mode and registered round outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= 1'b0;
      cnt    <= 4'd0;
      out_q  <= '0;
      sel_q  <= 4'd0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode   <= mode_nxt;
      cnt    <= cnt_nxt;
      out_q  <= out_nxt;
      sel_q  <= sel_nxt;
      last_q <= last_nxt;
      done_q <= done_nxt;
    end
  end

  // Key bank: written only on the load handshake so K1..K16 may move afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else if (load_take) begin
      for (int i = 0; i < 16; i++) bank[i] <= load_keys[i];
    end
  end

  // Every output is a register or decoded purely from the state register.
  assign bus.load_ready   = (state == IDLE);
  assign bus.subkey_valid = (state == RUN);
  assign bus.subkey_out   = out_q;
  assign bus.round_cnt    = cnt;
  assign bus.key_sel      = sel_q;
  assign bus.last_round   = last_q;
  assign bus.done         = done_q;

endmodule
